// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with a circular return-address stack.
// Each cycle IADDR either increments, jumps, branches PC-relative, calls (push),
// returns (pop), or holds. stall freezes everything, including the error flag.
module pc_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           stall,
  input  logic [2:0]                     ctrl,
  input  logic [ADDR_W-1:0]              jump,
  input  logic [ADDR_W-1:0]              offset,
  output logic [ADDR_W-1:0]              IADDR,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(RAS_DEPTH - 1);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HOLD   = 3'b101;

  // Architectural state
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [PTR_W-1:0]  tp_reg, tp_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              err_reg, err_next;

  // Return-address storage; contents are not reset, only the pointer/count are
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

  logic              push;
  logic [PTR_W-1:0]  tp_inc;
  logic [PTR_W-1:0]  tp_dec;
  logic [ADDR_W-1:0] ret_addr;

  // Circular pointer neighbours; the depth need not be a power of two
  always_comb begin
    tp_inc   = (tp_reg == PTR_MAX) ? '0 : tp_reg + PTR_W'(1);
    tp_dec   = (tp_reg == '0) ? PTR_MAX : tp_reg - PTR_W'(1);
    ret_addr = pc_reg + STEP_V;
  end

  // Next-state decode of ctrl; stall or reserved codes leave all state as-is
  always_comb begin
    pc_next    = pc_reg;
    tp_next    = tp_reg;
    count_next = count_reg;
    err_next   = err_reg;
    push       = 1'b0;
    if (!stall) begin
      case (ctrl)
        OP_INC:    pc_next = pc_reg + STEP_V;
        OP_JUMP:   pc_next = jump;
        OP_BRANCH: pc_next = pc_reg + offset;
        OP_CALL: begin
          // A full stack silently drops its oldest entry: the slot at tp is
          // the oldest one when full, so the push overwrites it naturally.
          push    = 1'b1;
          pc_next = jump;
          tp_next = tp_inc;
          if (count_reg == CNT_MAX) begin
            err_next = 1'b1;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
        end
        OP_RET: begin
          // Popping an empty stack keeps IADDR and only raises the error flag
          if (count_reg == '0) begin
            err_next = 1'b1;
          end else begin
            pc_next    = ras_mem[tp_dec];
            tp_next    = tp_dec;
            count_next = count_reg - CNT_W'(1);
          end
        end
        OP_HOLD: pc_next = pc_reg;
        default: pc_next = pc_reg;
      endcase
    end
  end

  // State register with asynchronous reset to the reset vector and an empty stack
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pc_reg    <= RESET_V;
      tp_reg    <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      tp_reg    <= tp_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Stack write port; a write during reset is harmless since contents are discarded
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[tp_reg] <= ret_addr;
    end
  end

  // Status outputs decoded from registered state
  always_comb begin
    IADDR     = pc_reg;
    ras_count = count_reg;
    ras_empty = (count_reg == '0);
    ras_full  = (count_reg == CNT_MAX);
    ras_err   = err_reg;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized traffic, compared each
// cycle against a queue-based reference model of the PC and return stack.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        RST;
  logic        stall;
  logic [2:0]  ctrl;
  logic [31:0] jump;
  logic [31:0] offset;
  logic [31:0] IADDR;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  pc_sequencer #(
    .ADDR_W(32), .STEP(1), .RESET_VEC(0), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .RST(RST), .stall(stall), .ctrl(ctrl), .jump(jump), .offset(offset),
    .IADDR(IADDR), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: PC value, stack as a bounded queue (newest at back), sticky error
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit s, input logic [2:0] c, input logic [31:0] j,
                            input logic [31:0] o);
    if (!s) begin
      case (c)
        3'd0: m_pc = m_pc + 32'd1;
        3'd1: m_pc = j;
        3'd2: m_pc = m_pc + o;
        3'd3: begin
          m_ras.push_back(m_pc + 32'd1);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_err = 1'b1;
          end
          m_pc = j;
        end
        3'd4: begin
          if (m_ras.size() == 0) m_err = 1'b1;
          else m_pc = m_ras.pop_back();
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_iaddr"}, IADDR, m_pc);
    check({tag, "_count"}, 32'(ras_count), 32'(m_ras.size()));
    check({tag, "_empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
    check({tag, "_full"},  32'(ras_full),  32'(m_ras.size() == DEPTH));
    check({tag, "_err"},   32'(ras_err),   32'(m_err));
  endtask

  // One transaction: drive at negedge, update model, sample 1 time unit after posedge
  task automatic cycle(input string tag, input bit s, input logic [2:0] c,
                       input logic [31:0] j, input logic [31:0] o);
    stall  = s;
    ctrl   = c;
    jump   = j;
    offset = o;
    model_step(s, c, j, o);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d %s stall=%0d ctrl=%0d jump=%h off=%h -> iaddr=%h cnt=%0d err=%0d",
             txn, tag, s, c, j, o, IADDR, ras_count, ras_err);
    check_all(tag);
    @(negedge clk);
  endtask

  // Assert reset between clock edges and confirm it acts without a clock edge
  task automatic async_reset(input string tag);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check({tag, "_async_iaddr"}, IADDR, 32'h0);
    check({tag, "_async_empty"}, 32'(ras_empty), 32'd1);
    check_all(tag);
    @(negedge clk);
    RST = 1'b0;
  endtask

  initial begin
    RST    = 1'b1;
    stall  = 1'b0;
    ctrl   = 3'd5;
    jump   = 32'h0;
    offset = 32'h0;
    model_reset();
    #1;
    check_all("por");
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;

    // 1: reset mid-cycle while IADDR=0x40 with a non-empty stack
    cycle("t1_call", 1'b0, 3'd3, 32'h40, 32'h0);
    check("t1_pre_iaddr", IADDR, 32'h40);
    async_reset("t1");

    // 2: increment and wrap
    cycle("t2_inc", 1'b0, 3'd0, 32'h0, 32'h0);
    check("t2_inc1", IADDR, 32'h1);
    cycle("t2_inc", 1'b0, 3'd0, 32'h0, 32'h0);
    cycle("t2_inc", 1'b0, 3'd0, 32'h0, 32'h0);
    check("t2_inc3", IADDR, 32'h3);
    cycle("t2_jmax", 1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0);
    cycle("t2_wrap", 1'b0, 3'd0, 32'h0, 32'h0);
    check("t2_wrap0", IADDR, 32'h0);

    // 3: negative branch, then jump
    cycle("t3_j100", 1'b0, 3'd1, 32'h100, 32'h0);
    cycle("t3_br", 1'b0, 3'd2, 32'h0, 32'hFFFF_FFF0);
    check("t3_br_f0", IADDR, 32'hF0);
    cycle("t3_br0", 1'b0, 3'd2, 32'h0, 32'h0);
    check("t3_br_zero", IADDR, 32'hF0);
    cycle("t3_jmp", 1'b0, 3'd1, 32'h2000, 32'h0);
    check("t3_jmp2000", IADDR, 32'h2000);

    // 4: nested call/return
    cycle("t4_j10", 1'b0, 3'd1, 32'h10, 32'h0);
    cycle("t4_call", 1'b0, 3'd3, 32'h80, 32'h0);
    check("t4_a", IADDR, 32'h80);  check("t4_ca", 32'(ras_count), 32'd1);
    cycle("t4_call", 1'b0, 3'd3, 32'h200, 32'h0);
    check("t4_b", IADDR, 32'h200); check("t4_cb", 32'(ras_count), 32'd2);
    cycle("t4_ret", 1'b0, 3'd4, 32'h0, 32'h0);
    check("t4_c", IADDR, 32'h81);  check("t4_cc", 32'(ras_count), 32'd1);
    cycle("t4_ret", 1'b0, 3'd4, 32'h0, 32'h0);
    check("t4_d", IADDR, 32'h11);  check("t4_cd", 32'(ras_count), 32'd0);
    check("t4_noerr", 32'(ras_err), 32'd0);

    // 5: overflow then drain and underflow
    async_reset("t5");
    for (int i = 0; i < 5; i++) begin
      cycle("t5_call", 1'b0, 3'd3, 32'h1000 + 32'(i) * 32'h10, 32'h0);
    end
    check("t5_full", 32'(ras_full), 32'd1);
    check("t5_err", 32'(ras_err), 32'd1);
    for (int i = 4; i >= 1; i--) begin
      cycle("t5_ret", 1'b0, 3'd4, 32'h0, 32'h0);
      // The return address of the call to 0x1000+i*0x10 is the previous target +1
      check("t5_ret_addr", IADDR, 32'h1000 + 32'(i - 1) * 32'h10 + 32'd1);
    end
    cycle("t5_ret_empty", 1'b0, 3'd4, 32'h0, 32'h0);
    check("t5_unchanged", IADDR, 32'h1001);
    check("t5_empty", 32'(ras_empty), 32'd1);

    // 6: stall overrides CALL, then CALL lands on release
    async_reset("t6");
    cycle("t6_j", 1'b0, 3'd1, 32'h300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle("t6_stall", 1'b1, 3'd3, 32'h500, 32'h0);
      check("t6_hold", IADDR, 32'h300);
    end
    cycle("t6_call", 1'b0, 3'd3, 32'h500, 32'h0);
    check("t6_go", IADDR, 32'h500);
    check("t6_cnt", 32'(ras_count), 32'd1);
    // stalled RET on empty stack must not set the error flag
    cycle("t6_ret", 1'b0, 3'd4, 32'h0, 32'h0);
    cycle("t6_sret", 1'b1, 3'd4, 32'h0, 32'h0);
    check("t6_no_err", 32'(ras_err), 32'd0);

    // Randomized traffic, with occasional asynchronous reset
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rj;
      logic [31:0] ro;
      logic [2:0]  rc;
      bit          rs;
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end
      rc = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rc = 3'd3;
      if ($urandom_range(0, 2) == 0) rc = 3'd4;
      rs = ($urandom_range(0, 4) == 0);
      rj = $urandom;
      ro = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      cycle("rnd", rs, rc, rj, ro);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
